// File: rtl/dht11_pkg.sv
// Shared command/response codes, FSM state type and helpers for the DHT11 read scheduler.
package dht11_pkg;

   localparam logic [7:0] CMD_TEMP_INT   = 8'h01;
   localparam logic [7:0] CMD_HUM_INT    = 8'h02;
   localparam logic [7:0] CMD_TEMP_FLOAT = 8'h03;
   localparam logic [7:0] CMD_HUM_FLOAT  = 8'h04;
   localparam logic [7:0] CMD_STATUS     = 8'h05;

   localparam logic [7:0] RSP_OK         = 8'h10;
   localparam logic [7:0] RSP_STATUS     = 8'h1F;
   localparam logic [7:0] RSP_SNS_ERR    = 8'hE1;
   localparam logic [7:0] RSP_CHK_ERR    = 8'hE2;
   localparam logic [7:0] RSP_TIMEOUT    = 8'hE3;
   localparam logic [7:0] RSP_INVALID    = 8'hEF;

   localparam logic [7:0] SENSOR_ENABLE_CODE = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_GAP_WAIT,
      ST_START,
      ST_RUN,
      ST_CHECK,
      ST_RESP
   } state_t;

   function automatic logic is_read_cmd(input logic [7:0] code);
      return (code >= CMD_TEMP_INT) && (code <= CMD_HUM_FLOAT);
   endfunction

   // Picks the byte a read command asks for; non-read codes yield 0.
   function automatic logic [7:0] select_byte(input logic [7:0] code,
                                              input logic [7:0] hum_int,
                                              input logic [7:0] hum_float,
                                              input logic [7:0] temp_int,
                                              input logic [7:0] temp_float);
      case (code)
         CMD_TEMP_INT:   return temp_int;
         CMD_HUM_INT:    return hum_int;
         CMD_TEMP_FLOAT: return temp_float;
         CMD_HUM_FLOAT:  return hum_float;
         default:        return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/dht11_interval_timer.sv
// Saturating interval counter: counts every cycle up to LIMIT, flags when it gets there.
module dht11_interval_timer #(
   parameter int LIMIT = 100_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (count != W'(LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == W'(LIMIT));

endmodule

// File: rtl/dht11_read_scheduler.sv
// Command/response front end for a DHT11 reader: rate-limits sensor transactions,
// caches the last good reading and reports sensor, checksum and timeout faults.
module dht11_read_scheduler
   import dht11_pkg::*;
#(
   parameter int MIN_GAP_CYCLES = 100_000_000,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_code,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_code,
   output logic [7:0] rsp_data,
   output logic [7:0] sns_enable,
   output logic       sns_reset,
   input  logic       sns_done,
   input  logic       sns_error,
   input  logic       sns_hold,
   input  logic [7:0] sns_hum_int,
   input  logic [7:0] sns_hum_float,
   input  logic [7:0] sns_temp_int,
   input  logic [7:0] sns_temp_float,
   input  logic [7:0] sns_checksum
);

   state_t      state;
   logic [7:0]  cmd;
   logic        cache_valid;
   logic [7:0]  hum_int_c, hum_float_c, temp_int_c, temp_float_c;
   logic [25:0] timeout_count;
   logic [25:0] timeout_inc;
   logic        gap_expired;
   logic [7:0]  sum;
   logic [7:0] cached_byte, live_byte;

   // The gap restarts at every transaction start, so starts are at least MIN_GAP_CYCLES apart.
   dht11_interval_timer #(.LIMIT(MIN_GAP_CYCLES)) gap_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (state == ST_START),
      .expired (gap_expired)
   );

   assign timeout_inc = timeout_count + 26'd1;
   assign sum         = sns_hum_int + sns_hum_float + sns_temp_int + sns_temp_float;
   assign cached_byte = select_byte(cmd, hum_int_c, hum_float_c, temp_int_c, temp_float_c);
   assign live_byte   = select_byte(cmd, sns_hum_int, sns_hum_float, sns_temp_int, sns_temp_float);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         cmd           <= 8'h00;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_code      <= 8'h00;
         rsp_data      <= 8'h00;
         sns_enable    <= 8'h00;
         sns_reset     <= 1'b0;
         cache_valid   <= 1'b0;
         hum_int_c     <= 8'h00;
         hum_float_c   <= 8'h00;
         temp_int_c    <= 8'h00;
         temp_float_c  <= 8'h00;
         timeout_count <= 26'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd       <= cmd_code;
                  cmd_ready <= 1'b0;
                  state     <= ST_DECODE;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            ST_DECODE: begin
               if (cmd == CMD_STATUS) begin
                  rsp_valid <= 1'b1;
                  rsp_code  <= RSP_STATUS;
                  rsp_data  <= {6'b0, cache_valid, gap_expired};
                  state     <= ST_RESP;
               end else if (!is_read_cmd(cmd)) begin
                  rsp_valid <= 1'b1;
                  rsp_code  <= RSP_INVALID;
                  rsp_data  <= 8'h00;
                  state     <= ST_RESP;
               end else if (cache_valid && !gap_expired) begin
                  rsp_valid <= 1'b1;
                  rsp_code  <= RSP_OK;
                  rsp_data  <= cached_byte;
                  state     <= ST_RESP;
               end else begin
                  state <= ST_GAP_WAIT;
               end
            end
            ST_GAP_WAIT: begin
               if (gap_expired) begin
                  sns_enable <= SENSOR_ENABLE_CODE;
                  sns_reset  <= 1'b1;
                  state      <= ST_START;
               end
            end
            ST_START: begin
               sns_reset     <= 1'b0;
               timeout_count <= 26'd0;
               state         <= ST_RUN;
            end
            ST_RUN: begin
               if (sns_error) begin
                  sns_enable  <= 8'h00;
                  cache_valid <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_code    <= RSP_SNS_ERR;
                  rsp_data    <= 8'h00;
                  state       <= ST_RESP;
               end else if (sns_done && !sns_hold) begin
                  sns_enable <= 8'h00;
                  state      <= ST_CHECK;
               end else begin
                  timeout_count <= timeout_inc;
                  if (timeout_inc == 26'(TIMEOUT_CYCLES)) begin
                     sns_enable  <= 8'h00;
                     cache_valid <= 1'b0;
                     rsp_valid   <= 1'b1;
                     rsp_code    <= RSP_TIMEOUT;
                     rsp_data    <= 8'h00;
                     state       <= ST_RESP;
                  end
               end
            end
            ST_CHECK: begin
               rsp_valid <= 1'b1;
               state     <= ST_RESP;
               if (sum == sns_checksum) begin
                  hum_int_c    <= sns_hum_int;
                  hum_float_c  <= sns_hum_float;
                  temp_int_c   <= sns_temp_int;
                  temp_float_c <= sns_temp_float;
                  cache_valid  <= 1'b1;
                  rsp_code     <= RSP_OK;
                  rsp_data     <= live_byte;
               end else begin
                  cache_valid <= 1'b0;
                  rsp_code    <= RSP_CHK_ERR;
                  rsp_data    <= 8'h00;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
